// File: rtl/pc_reg_bp_if.sv
// ---------------------------------------------------------------------------
// pc_reg_bp_if
//   Bundle of the signals that run between the PC/branch-predictor stage and
//   its neighbours (IF consumes the fetch PC, EX supplies redirects and
//   branch resolutions).
//
//   stall_i               hold the current PC
//   ex_mispredict_i       EX redirect request
//   ex_redirect_pc_i      PC to load on a redirect (loaded unmodified)
//   ex_br_valid_i         a branch resolved in EX this cycle
//   ex_br_pc_i            PC of the resolved branch
//   ex_br_taken_i         resolved direction
//   ex_br_target_i        resolved taken target
//   pc_o                  current fetch PC
//   without_prediction_o  fall-through PC (pc_o + 4)
//   pred_taken_o          next PC comes from the BTB target
//
//   master : the pipeline side that drives stall/redirect/training
//   slave  : the PC stage itself
// ---------------------------------------------------------------------------
interface pc_reg_bp_if;
    logic        stall_i;
    logic        ex_mispredict_i;
    logic [31:0] ex_redirect_pc_i;
    logic        ex_br_valid_i;
    logic [31:0] ex_br_pc_i;
    logic        ex_br_taken_i;
    logic [31:0] ex_br_target_i;
    logic [31:0] pc_o;
    logic [31:0] without_prediction_o;
    logic        pred_taken_o;

    modport master (
        output stall_i, ex_mispredict_i, ex_redirect_pc_i,
        output ex_br_valid_i, ex_br_pc_i, ex_br_taken_i, ex_br_target_i,
        input  pc_o, without_prediction_o, pred_taken_o
    );

    modport slave (
        input  stall_i, ex_mispredict_i, ex_redirect_pc_i,
        input  ex_br_valid_i, ex_br_pc_i, ex_br_taken_i, ex_br_target_i,
        output pc_o, without_prediction_o, pred_taken_o
    );
endinterface

// File: rtl/pc_reg_bp.sv
// ---------------------------------------------------------------------------
// pc_reg_bp
//   Program-counter stage with a direct-mapped BTB and 2-bit saturating
//   direction counters. Next PC priority: EX redirect, stall hold, then the
//   BTB prediction (target when hit and counter MSB set, else pc + 4).
//   EX branch resolutions train the BTB every cycle they are valid,
//   regardless of stall or redirect.
//
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   pc_reg_bp_if.slave (see the interface file for signal list)
// ---------------------------------------------------------------------------
module pc_reg_bp #(
    parameter int          IDX_W    = 6,
    parameter int          TAG_W    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    pc_reg_bp_if.slave    bus
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [31:0]      pc_q;
    logic [31:0]      fall_through;
    logic [31:0]      pred_next;
    logic             pred_taken;

    logic             btb_valid  [ENTRIES];
    logic [TAG_W-1:0] btb_tag    [ENTRIES];
    logic [29:0]      btb_target [ENTRIES];
    logic [1:0]       btb_ctr    [ENTRIES];

    // ---------------- lookup on the current fetch PC ----------------
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;

    assign rd_idx       = pc_q[IDX_W+1:2];
    assign rd_tag       = pc_q[IDX_W+TAG_W+1:IDX_W+2];
    assign rd_hit       = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign pred_taken   = rd_hit && btb_ctr[rd_idx][1];
    assign fall_through = pc_q + 32'd4;

    always_comb begin
        // NOTE: default assignment first so every path drives pred_next; a
        // missing else in combinational logic would infer a latch.
        pred_next = fall_through;
        if (pred_taken) begin
            pred_next = {btb_target[rd_idx], 2'b00};
        end
    end

    assign bus.pc_o                 = pc_q;
    assign bus.without_prediction_o = fall_through;
    assign bus.pred_taken_o         = pred_taken;

    // ---------------- PC register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (bus.ex_mispredict_i) begin
            pc_q <= bus.ex_redirect_pc_i;
        end else if (!bus.stall_i) begin
            pc_q <= pred_next;
        end
    end

    // ---------------- training on EX resolution ----------------
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic [1:0]       wr_ctr;

    assign wr_idx = bus.ex_br_pc_i[IDX_W+1:2];
    assign wr_tag = bus.ex_br_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign wr_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
    assign wr_ctr = btb_ctr[wr_idx];

    // NOTE: only valid bits and counters carry a reset; tags and targets are
    // never consulted while valid = 0, so they stay plain (reset-free) storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'b01;
            end
        end else if (bus.ex_br_valid_i) begin
            if (wr_hit) begin
                if (bus.ex_br_taken_i) begin
                    if (wr_ctr != 2'b11) btb_ctr[wr_idx] <= wr_ctr + 2'd1;
                end else begin
                    if (wr_ctr != 2'b00) btb_ctr[wr_idx] <= wr_ctr - 2'd1;
                end
            end else if (bus.ex_br_taken_i) begin
                btb_valid[wr_idx] <= 1'b1;
                btb_ctr[wr_idx]   <= 2'b10;
            end
        end
    end

    // A taken resolution always leaves this entry holding its tag and target:
    // on a hit the tag is rewritten with the same value, on a miss it allocates.
    always_ff @(posedge clk) begin
        if (bus.ex_br_valid_i && bus.ex_br_taken_i) begin
            btb_tag[wr_idx]    <= wr_tag;
            btb_target[wr_idx] <= bus.ex_br_target_i[31:2];
        end
    end

    // Bits not used by the indexing/tagging scheme.
    logic unused_bits;
    assign unused_bits = ^{bus.ex_br_pc_i[1:0],
                           bus.ex_br_pc_i[31:IDX_W+TAG_W+2],
                           bus.ex_br_target_i[1:0]};

endmodule
